seg_addr_gen: RTL and testbench



---
 rtl/seg_addr_gen.sv | 132 +++++++++++++
 tb/tb_seg_addr_gen.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/seg_addr_gen.sv
// Physical address generator: turns segment-select + offset requests into
// (segment << SEG_SHIFT) + offset bus cycles, splitting odd word accesses in two.
module seg_addr_gen #(
    parameter int SEG_SHIFT = 4,
    parameter int PA_W      = 20
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [15:0]     cs_in,
    input  logic [15:0]     ds_in,
    input  logic [15:0]     ss_in,
    input  logic [15:0]     es_in,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [1:0]      req_seg_sel,
    input  logic [15:0]     req_offset,
    input  logic            req_word,
    input  logic            req_write,
    output logic            bus_valid,
    input  logic            bus_ready,
    output logic [PA_W-1:0] bus_addr,
    output logic [1:0]      bus_byte_en,
    output logic            bus_write,
    output logic            bus_last
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE1 = 2'd1,
        ISSUE2 = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [15:0]     lat_seg, lat_seg_nxt;
    logic [15:0]     lat_off, lat_off_nxt;
    logic [PA_W-1:0] addr_nxt;
    logic [1:0]      byte_en_nxt;
    logic            write_nxt;
    logic            last_nxt;

    logic [15:0]     sel_seg;
    logic [15:0]     off2;
    logic [PA_W-1:0] pa_new;
    logic            bus_fire;
    logic            accept;

    function automatic logic [PA_W-1:0] phys_addr(input logic [15:0] seg,
                                                  input logic [15:0] off);
        logic [PA_W-1:0] base;
        base = PA_W'(seg) << SEG_SHIFT;
        return base + PA_W'(off);
    endfunction

    always_comb begin
        sel_seg = cs_in;
        case (req_seg_sel)
            2'd0: sel_seg = cs_in;
            2'd1: sel_seg = ds_in;
            2'd2: sel_seg = ss_in;
            2'd3: sel_seg = es_in;
            default: sel_seg = cs_in;
        endcase
    end

    // The segment value itself is latched, so later register-file updates
    // cannot disturb a request that is already in flight.
    assign bus_valid = (state != IDLE);
    assign bus_fire  = bus_valid && bus_ready;
    assign req_ready = (state == IDLE) || (bus_fire && bus_last);
    assign accept    = req_valid && req_ready;
    assign pa_new    = phys_addr(sel_seg, req_offset);
    assign off2      = lat_off + 16'd1;

    always_comb begin
        state_nxt   = state;
        lat_seg_nxt = lat_seg;
        lat_off_nxt = lat_off;
        addr_nxt    = bus_addr;
        byte_en_nxt = bus_byte_en;
        write_nxt   = bus_write;
        last_nxt    = bus_last;

        if (accept) begin
            state_nxt   = ISSUE1;
            lat_seg_nxt = sel_seg;
            lat_off_nxt = req_offset;
            addr_nxt    = pa_new;
            write_nxt   = req_write;
            if (!req_word) begin
                byte_en_nxt = pa_new[0] ? 2'b10 : 2'b01;
                last_nxt    = 1'b1;
            end else if (req_offset[0]) begin
                byte_en_nxt = 2'b10;
                last_nxt    = 1'b0;
            end else begin
                byte_en_nxt = 2'b11;
                last_nxt    = 1'b1;
            end
        end else if (bus_fire && !bus_last) begin
            // Second half of an odd word: offset wraps inside the segment.
            state_nxt   = ISSUE2;
            addr_nxt    = phys_addr(lat_seg, off2);
            byte_en_nxt = 2'b01;
            last_nxt    = 1'b1;
        end else if (bus_fire) begin
            state_nxt   = IDLE;
            byte_en_nxt = 2'b00;
            last_nxt    = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            lat_seg     <= '0;
            lat_off     <= '0;
            bus_addr    <= '0;
            bus_byte_en <= 2'b00;
            bus_write   <= 1'b0;
            bus_last    <= 1'b0;
        end else begin
            state       <= state_nxt;
            lat_seg     <= lat_seg_nxt;
            lat_off     <= lat_off_nxt;
            bus_addr    <= addr_nxt;
            bus_byte_en <= byte_en_nxt;
            bus_write   <= write_nxt;
            bus_last    <= last_nxt;
        end
    end

endmodule

// File: tb/tb_seg_addr_gen.sv
// Directed bench for seg_addr_gen: hand-computed addresses, lanes and handshakes.
module tb_seg_addr_gen;

    logic        clk;
    logic        rst;
    logic [15:0] cs_in, ds_in, ss_in, es_in;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_seg_sel;
    logic [15:0] req_offset;
    logic        req_word;
    logic        req_write;
    logic        bus_valid;
    logic        bus_ready;
    logic [19:0] bus_addr;
    logic [1:0]  bus_byte_en;
    logic        bus_write;
    logic        bus_last;

    int errors = 0;
    int checks = 0;

    seg_addr_gen #(.SEG_SHIFT(4), .PA_W(20)) dut (
        .clk(clk), .rst(rst),
        .cs_in(cs_in), .ds_in(ds_in), .ss_in(ss_in), .es_in(es_in),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_seg_sel(req_seg_sel), .req_offset(req_offset),
        .req_word(req_word), .req_write(req_write),
        .bus_valid(bus_valid), .bus_ready(bus_ready),
        .bus_addr(bus_addr), .bus_byte_en(bus_byte_en),
        .bus_write(bus_write), .bus_last(bus_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [19:0] got, input logic [19:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic checkOutput(input string tag, input logic v, input logic [19:0] a,
                               input logic [1:0] en, input logic w, input logic l);
        checkVal({tag, ".valid"}, {19'd0, bus_valid}, {19'd0, v});
        if (v) begin
            checkVal({tag, ".addr"}, bus_addr, a);
            checkVal({tag, ".byte_en"}, {18'd0, bus_byte_en}, {18'd0, en});
            checkVal({tag, ".write"}, {19'd0, bus_write}, {19'd0, w});
            checkVal({tag, ".last"}, {19'd0, bus_last}, {19'd0, l});
        end
    endtask

    task automatic applyStimulus(input logic [1:0] sel, input logic [15:0] off,
                                 input logic word, input logic wr);
        req_valid   = 1'b1;
        req_seg_sel = sel;
        req_offset  = off;
        req_word    = word;
        req_write   = wr;
    endtask

    initial begin
        rst = 1'b1;
        cs_in = 16'h0; ds_in = 16'h0; ss_in = 16'h0; es_in = 16'h0;
        req_valid = 1'b0; req_seg_sel = 2'd0; req_offset = 16'h0;
        req_word = 1'b0; req_write = 1'b0; bus_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        checkVal("reset.valid", {19'd0, bus_valid}, 20'd0);
        checkVal("reset.addr", bus_addr, 20'h00000);
        checkVal("reset.byte_en", {18'd0, bus_byte_en}, 20'd0);
        checkVal("reset.write", {19'd0, bus_write}, 20'd0);
        checkVal("reset.last", {19'd0, bus_last}, 20'd0);
        checkVal("reset.req_ready", {19'd0, req_ready}, 20'd1);

        // Byte read at F000:FFF0
        @(negedge clk);
        cs_in = 16'hF000;
        applyStimulus(2'd0, 16'hFFF0, 1'b0, 1'b0);
        @(negedge clk);
        req_valid = 1'b0;
        checkOutput("t1", 1'b1, 20'hFFFF0, 2'b01, 1'b0, 1'b1);
        checkVal("t1.req_ready_busy", {19'd0, req_ready}, 20'd0);
        bus_ready = 1'b1;
        @(negedge clk);
        bus_ready = 1'b0;
        checkOutput("t1.idle", 1'b0, 20'h0, 2'b00, 1'b0, 1'b0);

        // Word write at FFFF:0010 wraps to 00000
        es_in = 16'hFFFF;
        applyStimulus(2'd3, 16'h0010, 1'b1, 1'b1);
        @(negedge clk);
        req_valid = 1'b0;
        checkOutput("t2", 1'b1, 20'h00000, 2'b11, 1'b1, 1'b1);
        bus_ready = 1'b1;
        @(negedge clk);
        bus_ready = 1'b0;
        checkOutput("t2.idle", 1'b0, 20'h0, 2'b00, 1'b0, 1'b0);

        // Odd word read at 1234:0005 splits into two byte cycles
        ds_in = 16'h1234;
        applyStimulus(2'd1, 16'h0005, 1'b1, 1'b0);
        @(negedge clk);
        req_valid = 1'b0;
        checkOutput("t3.c1", 1'b1, 20'h12345, 2'b10, 1'b0, 1'b0);
        bus_ready = 1'b1;
        #1;
        checkVal("t3.req_ready_mid", {19'd0, req_ready}, 20'd0);
        @(negedge clk);
        checkOutput("t3.c2", 1'b1, 20'h12346, 2'b01, 1'b0, 1'b1);
        checkVal("t3.req_ready_last", {19'd0, req_ready}, 20'd1);
        @(negedge clk);
        bus_ready = 1'b0;
        checkOutput("t3.idle", 1'b0, 20'h0, 2'b00, 1'b0, 1'b0);

        // Stalled odd word at 2000:FFFF, second half wraps offset to 0000
        ss_in = 16'h2000;
        applyStimulus(2'd2, 16'hFFFF, 1'b1, 1'b0);
        @(negedge clk);
        req_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("t4.stall%0d", i), 1'b1, 20'h2FFFF, 2'b10, 1'b0, 1'b0);
            @(negedge clk);
        end
        checkOutput("t4.stall3", 1'b1, 20'h2FFFF, 2'b10, 1'b0, 1'b0);
        bus_ready = 1'b1;
        @(negedge clk);
        checkOutput("t4.c2", 1'b1, 20'h20000, 2'b01, 1'b0, 1'b1);
        @(negedge clk);
        bus_ready = 1'b0;
        checkOutput("t4.idle", 1'b0, 20'h0, 2'b00, 1'b0, 1'b0);

        // Segment change after accept, then back-to-back handoff
        ds_in = 16'h1000;
        applyStimulus(2'd1, 16'h0002, 1'b1, 1'b0);
        @(negedge clk);
        req_valid = 1'b0;
        ds_in = 16'h5000;
        #1;
        checkOutput("t5.first", 1'b1, 20'h10002, 2'b11, 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("t5.hold", 1'b1, 20'h10002, 2'b11, 1'b0, 1'b1);
        bus_ready = 1'b1;
        applyStimulus(2'd1, 16'h0003, 1'b0, 1'b1);
        #1;
        checkVal("t5.handoff_ready", {19'd0, req_ready}, 20'd1);
        @(negedge clk);
        req_valid = 1'b0;
        checkOutput("t5.second", 1'b1, 20'h50003, 2'b10, 1'b1, 1'b1);
        @(negedge clk);
        bus_ready = 1'b0;
        checkOutput("t5.idle", 1'b0, 20'h0, 2'b00, 1'b0, 1'b0);

        // Reset during the second half of a split access
        ds_in = 16'h1234;
        applyStimulus(2'd1, 16'h0005, 1'b1, 1'b0);
        @(negedge clk);
        req_valid = 1'b0;
        bus_ready = 1'b1;
        checkOutput("t6.c1", 1'b1, 20'h12345, 2'b10, 1'b0, 1'b0);
        @(negedge clk);
        bus_ready = 1'b0;
        checkOutput("t6.c2", 1'b1, 20'h12346, 2'b01, 1'b0, 1'b1);
        rst = 1'b1;
        #1;
        checkVal("t6.rst_valid", {19'd0, bus_valid}, 20'd0);
        checkVal("t6.rst_addr", bus_addr, 20'h00000);
        @(negedge clk);
        rst = 1'b0;
        bus_ready = 1'b1;
        #1;
        checkVal("t6.req_ready", {19'd0, req_ready}, 20'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkVal($sformatf("t6.no_issue%0d", i), {19'd0, bus_valid}, 20'd0);
        end
        bus_ready = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
